decode_queue: RTL and testbench

- Parametrised instruction decode stage with a built-in decoded-instruction queue.
- Sits between fetch and the Tomasulo dispatch/issue logic.
- Decodes the supported MIPS subset at enqueue and buffers up to QUEUE_DEPTH decoded entries.
- Presents the oldest entry to dispatch over a valid/ready handshake; supports pipeline flush on branch redirect.

---
 rtl/decode_queue.sv | 180 ++++++++++++++++++
 tb/tb_decode_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue.sv
// MIPS-subset decode stage with a FIFO of decoded entries feeding dispatch.
// Define DECODE_ILLEGAL_DROP_EN to consume illegal instructions instead of queueing them.
module decode_queue #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter int unsigned CNT_WIDTH   = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [PC_WIDTH-1:0]   in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [5:0]            out_op,
  output logic [4:0]            out_src1,
  output logic [4:0]            out_src2,
  output logic [4:0]            out_dest,
  output logic                  out_use_src1,
  output logic                  out_use_src2,
  output logic                  out_use_dest,
  output logic [DATA_WIDTH-1:0] out_imm,
  output logic                  out_illegal,
  output logic [31:0]           out_instr,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [CNT_WIDTH-1:0]  out_count
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [PTR_W-1:0]     LAST_PTR = PTR_W'(QUEUE_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C  = CNT_WIDTH'(QUEUE_DEPTH);

  typedef enum logic [5:0] {
    OP_ADD = 6'd0, OP_ADDI = 6'd1, OP_SUB = 6'd2, OP_SLL = 6'd3, OP_SRL = 6'd4,
    OP_MUL = 6'd5, OP_LW = 6'd6, OP_SW = 6'd7, OP_BNE = 6'd8, OP_LI = 6'd9,
    OP_ILLEGAL = 6'd63
  } op_e;

  typedef struct packed {
    logic [5:0]            op;
    logic [4:0]            src1;
    logic [4:0]            src2;
    logic [4:0]            dest;
    logic                  use_src1;
    logic                  use_src2;
    logic                  use_dest;
    logic [DATA_WIDTH-1:0] imm;
    logic                  illegal;
    logic [31:0]           instr;
    logic [PC_WIDTH-1:0]   pc;
  } entry_t;

  entry_t                 dec;
  entry_t                 mem [QUEUE_DEPTH];
  logic [PTR_W-1:0]       rd_ptr, wr_ptr, disp_ptr;
  logic [PTR_W-1:0]       rd_nxt, wr_nxt, disp_nxt;
  logic [CNT_WIDTH-1:0]   count, cnt_nxt;
  logic                   push, enq, pop;
  logic [5:0]             opcode, funct;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    dec       = '0;
    dec.instr = in_instr;
    dec.pc    = in_pc;
    opcode    = in_instr[31:26];
    funct     = in_instr[5:0];
    dec.op    = OP_ILLEGAL;
    dec.illegal = 1'b1;
    if ((opcode == 6'h00 && (funct == 6'h20 || funct == 6'h22)) ||
        (opcode == 6'h1C && funct == 6'h02)) begin
      dec.op      = (opcode == 6'h1C) ? OP_MUL : (funct == 6'h20) ? OP_ADD : OP_SUB;
      dec.illegal = 1'b0;
      dec.src1    = in_instr[25:21];
      dec.src2    = in_instr[20:16];
      dec.dest    = in_instr[15:11];
      dec.use_src1 = 1'b1;
      dec.use_src2 = 1'b1;
      dec.use_dest = 1'b1;
    end else if (opcode == 6'h00 && (funct == 6'h00 || funct == 6'h02)) begin
      dec.op      = (funct == 6'h00) ? OP_SLL : OP_SRL;
      dec.illegal = 1'b0;
      dec.src1    = in_instr[20:16];
      dec.dest    = in_instr[15:11];
      dec.imm     = DATA_WIDTH'(in_instr[10:6]);
      dec.use_src1 = 1'b1;
      dec.use_dest = 1'b1;
    end else if (opcode == 6'h08 || opcode == 6'h23) begin
      dec.op      = (opcode == 6'h08) ? OP_ADDI : OP_LW;
      dec.illegal = 1'b0;
      dec.dest    = in_instr[25:21];
      dec.src1    = in_instr[20:16];
      dec.imm     = DATA_WIDTH'($signed(in_instr[15:0]));
      dec.use_src1 = 1'b1;
      dec.use_dest = 1'b1;
    end else if (opcode == 6'h30) begin
      dec.op      = OP_LI;
      dec.illegal = 1'b0;
      dec.dest    = in_instr[25:21];
      dec.imm     = DATA_WIDTH'(in_instr[15:0]);
      dec.use_dest = 1'b1;
    end else if (opcode == 6'h2B || opcode == 6'h05) begin
      dec.op      = (opcode == 6'h2B) ? OP_SW : OP_BNE;
      dec.illegal = 1'b0;
      dec.src1    = in_instr[25:21];
      dec.src2    = in_instr[20:16];
      dec.imm     = DATA_WIDTH'($signed(in_instr[15:0]));
      dec.use_src1 = 1'b1;
      dec.use_src2 = 1'b1;
    end
  end

  assign out_valid = (count != '0);
  assign in_ready  = (count < DEPTH_C);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
`ifdef DECODE_ILLEGAL_DROP_EN
  assign enq       = push && !dec.illegal;
`else
  assign enq       = push;
`endif

  // disp_ptr only follows rd_ptr while entries exist, so outputs hold once drained
  always_comb begin
    rd_nxt   = rd_ptr;
    wr_nxt   = wr_ptr;
    cnt_nxt  = count;
    disp_nxt = disp_ptr;
    if (flush) begin
      rd_nxt  = '0;
      wr_nxt  = '0;
      cnt_nxt = '0;
    end else begin
      if (enq) wr_nxt = ptr_inc(wr_ptr);
      if (pop) rd_nxt = ptr_inc(rd_ptr);
      case ({enq, pop})
        2'b10:   cnt_nxt = count + CNT_WIDTH'(1);
        2'b01:   cnt_nxt = count - CNT_WIDTH'(1);
        default: cnt_nxt = count;
      endcase
    end
    if (cnt_nxt != '0) disp_nxt = rd_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      disp_ptr <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < QUEUE_DEPTH; i++) mem[i] <= '0;
    end else begin
      rd_ptr   <= rd_nxt;
      wr_ptr   <= wr_nxt;
      disp_ptr <= disp_nxt;
      count    <= cnt_nxt;
      if (enq && !flush) mem[wr_ptr] <= dec;
    end
  end

  assign out_op       = mem[disp_ptr].op;
  assign out_src1     = mem[disp_ptr].src1;
  assign out_src2     = mem[disp_ptr].src2;
  assign out_dest     = mem[disp_ptr].dest;
  assign out_use_src1 = mem[disp_ptr].use_src1;
  assign out_use_src2 = mem[disp_ptr].use_src2;
  assign out_use_dest = mem[disp_ptr].use_dest;
  assign out_imm      = mem[disp_ptr].imm;
  assign out_illegal  = mem[disp_ptr].illegal;
  assign out_instr    = mem[disp_ptr].instr;
  assign out_pc       = mem[disp_ptr].pc;
  assign out_count    = count;

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue (default depth 4, 32-bit widths).
module tb_decode_queue;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_imm, out_instr, out_pc;
  logic [5:0]  out_op;
  logic [4:0]  out_src1, out_src2, out_dest;
  logic        out_use_src1, out_use_src2, out_use_dest, out_illegal;
  logic [2:0]  out_count;

  int tests = 0;
  int fails = 0;

  logic [31:0] tv_instr [8] = '{32'h00853022, 32'h002740C0, 32'h000957C2, 32'h70221802,
                                32'h8C5D0010, 32'hAC7D8000, 32'h1422FFFE, 32'h00221820};
  logic [5:0]  tv_op    [8] = '{6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7, 6'd8, 6'd0};
  logic [14:0] tv_regs  [8] = '{{5'd4, 5'd5, 5'd6}, {5'd7, 5'd0, 5'd8}, {5'd9, 5'd0, 5'd10},
                                {5'd1, 5'd2, 5'd3}, {5'd29, 5'd0, 5'd2}, {5'd3, 5'd29, 5'd0},
                                {5'd1, 5'd2, 5'd0}, {5'd1, 5'd2, 5'd3}};
  logic [2:0]  tv_use   [8] = '{3'b111, 3'b101, 3'b101, 3'b111, 3'b101, 3'b110, 3'b110, 3'b111};
  logic [31:0] tv_imm   [8] = '{32'h0, 32'h3, 32'h1F, 32'h0, 32'h10, 32'hFFFF8000,
                                32'hFFFFFFFE, 32'h0};

  decode_queue #(.DATA_WIDTH(32), .PC_WIDTH(32), .QUEUE_DEPTH(4), .CNT_WIDTH(3)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_src1(out_src1), .out_src2(out_src2), .out_dest(out_dest),
    .out_use_src1(out_use_src1), .out_use_src2(out_use_src2), .out_use_dest(out_use_dest),
    .out_imm(out_imm), .out_illegal(out_illegal), .out_instr(out_instr), .out_pc(out_pc),
    .out_count(out_count)
  );

  always #5 clock = ~clock;

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1; in_instr = instr; in_pc = pc;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_one;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step();
    reset = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0h want 0", out_valid); end
    tests++; if (out_count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", out_count); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0h want 1", in_ready); end
    tests++; if ({out_op, out_illegal, out_imm, out_pc} !== '0) begin fails++;
      $display("FAIL reset_data op=%0d ill=%0h imm=%h pc=%h want all 0", out_op, out_illegal, out_imm, out_pc); end
  endtask

  task automatic test_single_add;
    push_one(32'h00221820, 32'h100);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL add_valid got %0h want 1", out_valid); end
    tests++; if ({out_op, out_src1, out_src2, out_dest} !== {6'd0, 5'd1, 5'd2, 5'd3}) begin fails++;
      $display("FAIL add_fields op=%0d s1=%0d s2=%0d d=%0d want 0,1,2,3", out_op, out_src1, out_src2, out_dest); end
    tests++; if ({out_use_src1, out_use_src2, out_use_dest} !== 3'b111) begin fails++;
      $display("FAIL add_use got %b want 111", {out_use_src1, out_use_src2, out_use_dest}); end
    tests++; if (out_count !== 3'd1) begin fails++; $display("FAIL add_count got %0d want 1", out_count); end
    tests++; if ({out_instr, out_pc} !== {32'h00221820, 32'h100}) begin fails++;
      $display("FAIL add_pass instr=%h pc=%h want 00221820 00000100", out_instr, out_pc); end
    pop_one();
    tests++; if ({out_valid, out_count} !== 4'b0_000) begin fails++;
      $display("FAIL add_drain valid=%0h count=%0d want 0 0", out_valid, out_count); end
  endtask

  task automatic test_addi_li;
    in_valid = 1'b1; in_instr = 32'h2085FFFF; in_pc = 32'h200;
    step();
    in_instr = 32'hC0A01234; in_pc = 32'h204;
    step();
    in_valid = 1'b0;
    tests++; if ({out_op, out_dest, out_src1, out_src2, out_imm} !== {6'd1, 5'd4, 5'd5, 5'd0, 32'hFFFFFFFF}) begin fails++;
      $display("FAIL addi_fields op=%0d d=%0d s1=%0d s2=%0d imm=%h want 1,4,5,0,ffffffff", out_op, out_dest, out_src1, out_src2, out_imm); end
    tests++; if (out_count !== 3'd2) begin fails++; $display("FAIL addi_count got %0d want 2", out_count); end
    pop_one();
    tests++; if ({out_op, out_dest, out_src1, out_imm} !== {6'd9, 5'd5, 5'd0, 32'h00001234}) begin fails++;
      $display("FAIL li_fields op=%0d d=%0d s1=%0d imm=%h want 9,5,0,00001234", out_op, out_dest, out_src1, out_imm); end
    tests++; if ({out_use_src1, out_use_src2, out_use_dest} !== 3'b001) begin fails++;
      $display("FAIL li_use got %b want 001", {out_use_src1, out_use_src2, out_use_dest}); end
    pop_one();
  endtask

  task automatic test_decode_table;
    for (int i = 0; i < 8; i++) begin
      push_one(tv_instr[i], 32'h300 + 32'(i));
      tests++;
      if ({out_op, out_src1, out_src2, out_dest, out_use_src1, out_use_src2, out_use_dest, out_imm, out_illegal} !==
          {tv_op[i], tv_regs[i], tv_use[i], tv_imm[i], 1'b0}) begin
        fails++;
        $display("FAIL decode_%0d op=%0d s1=%0d s2=%0d d=%0d use=%b imm=%h ill=%0h want op=%0d regs=%h use=%b imm=%h ill=0",
                 i, out_op, out_src1, out_src2, out_dest, {out_use_src1, out_use_src2, out_use_dest}, out_imm, out_illegal,
                 tv_op[i], tv_regs[i], tv_use[i], tv_imm[i]);
      end
      pop_one();
    end
  endtask

  task automatic test_full_backpressure;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_instr = 32'h00000020 | (32'(i) << 11); in_pc = 32'h1000 + 32'(4 * i);
      tests++; if (in_ready !== (i < 4)) begin fails++; $display("FAIL full_in_ready_%0d got %0h want %0h", i, in_ready, (i < 4)); end
      step();
    end
    tests++; if ({out_count, in_ready} !== {3'd4, 1'b0}) begin fails++;
      $display("FAIL full_state count=%0d in_ready=%0h want 4 0", out_count, in_ready); end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tests++; if ({out_valid, out_pc, out_dest} !== {1'b1, 32'h1000 + 32'(4 * k), 5'(k)}) begin fails++;
        $display("FAIL full_order_%0d valid=%0h pc=%h d=%0d want 1 %h %0d", k, out_valid, out_pc, out_dest, 32'h1000 + 32'(4 * k), k); end
      step();
      if (k == 1) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    tests++; if (out_count !== 3'd0) begin fails++; $display("FAIL full_drain count=%0d want 0", out_count); end
  endtask

  task automatic test_push_pop_full;
    int np = 4;
    for (int i = 0; i < 4; i++) push_one(32'h00221820, 32'h4000 + 32'(4 * i));
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00221820;
    for (int c = 0; c < 8; c++) begin
      in_pc = 32'h4000 + 32'(4 * np);
      tests++; if ({in_ready, out_pc} !== {(c != 0), 32'h4000 + 32'(4 * c)}) begin fails++;
        $display("FAIL pp_pre_%0d in_ready=%0h pc=%h want %0h %h", c, in_ready, out_pc, (c != 0), 32'h4000 + 32'(4 * c)); end
      step();
      if (c != 0) np++;
      tests++; if (out_count !== 3'd3) begin fails++; $display("FAIL pp_count_%0d got %0d want 3", c, out_count); end
    end
    in_valid = 1'b0;
    for (int c = 8; c < 11; c++) begin
      tests++; if (out_pc !== 32'h4000 + 32'(4 * c)) begin fails++;
        $display("FAIL pp_tail_%0d pc=%h want %h", c, out_pc, 32'h4000 + 32'(4 * c)); end
      step();
    end
    out_ready = 1'b0;
    tests++; if (out_count !== 3'd0) begin fails++; $display("FAIL pp_drain count=%0d want 0", out_count); end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) push_one(32'h00221820, 32'h2000 + 32'(4 * i));
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h8C5D0010; in_pc = 32'hDEAD0000; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tests++; if ({out_valid, out_count, in_ready} !== {1'b0, 3'd0, 1'b1}) begin fails++;
      $display("FAIL flush_state valid=%0h count=%0d in_ready=%0h want 0 0 1", out_valid, out_count, in_ready); end
    push_one(32'h70221802, 32'h3000);
    tests++; if ({out_count, out_pc, out_op} !== {3'd1, 32'h3000, 6'd5}) begin fails++;
      $display("FAIL flush_after count=%0d pc=%h op=%0d want 1 00003000 5", out_count, out_pc, out_op); end
    pop_one();
  endtask

  task automatic test_reset_midstream;
    push_one(32'h00221820, 32'h5000);
    push_one(32'h00221820, 32'h5004);
    reset = 1'b1; in_valid = 1'b1; in_pc = 32'h5008;
    step();
    reset = 1'b0; in_valid = 1'b0;
    tests++; if ({out_valid, out_count, in_ready, out_op, out_pc} !== {1'b0, 3'd0, 1'b1, 6'd0, 32'h0}) begin fails++;
      $display("FAIL rst_mid valid=%0h count=%0d in_ready=%0h op=%0d pc=%h want 0 0 1 0 0", out_valid, out_count, in_ready, out_op, out_pc); end
  endtask

  task automatic test_illegal;
    in_valid = 1'b1; in_instr = 32'hFC000000; in_pc = 32'h6000;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL illegal_ready got %0h want 1", in_ready); end
    step();
    in_valid = 1'b0;
`ifdef DECODE_ILLEGAL_DROP_EN
    tests++; if ({out_valid, out_count} !== {1'b0, 3'd0}) begin fails++;
      $display("FAIL illegal_drop valid=%0h count=%0d want 0 0", out_valid, out_count); end
`else
    tests++; if ({out_valid, out_count, out_op, out_illegal} !== {1'b1, 3'd1, 6'd63, 1'b1}) begin fails++;
      $display("FAIL illegal_enq valid=%0h count=%0d op=%0d ill=%0h want 1 1 63 1", out_valid, out_count, out_op, out_illegal); end
    tests++; if ({out_src1, out_src2, out_dest, out_use_src1, out_use_src2, out_use_dest, out_imm} !== '0) begin fails++;
      $display("FAIL illegal_fields s1=%0d s2=%0d d=%0d imm=%h want all 0", out_src1, out_src2, out_dest, out_imm); end
    pop_one();
`endif
    push_one(32'h00221820, 32'h6004);
    tests++; if ({out_valid, out_count, out_pc, out_illegal} !== {1'b1, 3'd1, 32'h6004, 1'b0}) begin fails++;
      $display("FAIL illegal_next valid=%0h count=%0d pc=%h ill=%0h want 1 1 00006004 0", out_valid, out_count, out_pc, out_illegal); end
    pop_one();
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    test_reset();
    test_single_add();
    test_addi_li();
    test_decode_table();
    test_full_backpressure();
    test_push_pop_full();
    test_flush();
    test_reset_midstream();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
